// File: rtl/rom_rd_pkg.sv
// -----------------------------------------------------------------------------
// rom_rd_pkg
// Shared definitions for the sequential ROM reader.
//   - state_e      : reader FSM states
//   - ADDR_W_DEF   : default ROM address width (matches the ROM block)
//   - DATA_W_DEF   : default ROM data width (matches the ROM block)
// -----------------------------------------------------------------------------
package rom_rd_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/rom_seq_reader.sv
// -----------------------------------------------------------------------------
// rom_seq_reader
// Fetches LEN consecutive words from a registered-address ROM starting at BASE
// and presents each on a valid/ready port; pulses done after the last word.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, base, len  : burst request (sampled in IDLE only)
//   abort             : synchronous cancel of the running burst
//   busy, done        : status (done is a one-cycle pulse)
//   rom_en, rom_addr  : ROM control
//   rom_data          : ROM read data
//   out_data,
//   out_valid,
//   out_ready         : fetched-word stream with backpressure
// -----------------------------------------------------------------------------
module rom_seq_reader
    import rom_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              busy_q;
    logic              done_q;
    logic              rom_en_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    // Address of the following word; natural overflow gives the modulo wrap.
    logic [ADDR_W-1:0] next_addr_d;
    assign next_addr_d = cur_addr_q + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Abort beats everything, including a same-cycle handshake: the
            // presented word is dropped as if never consumed.
            if (state_q != S_IDLE && abort) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                rom_en_q    <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            cur_addr_q  <= base;
                            remaining_q <= len;
                            busy_q      <= 1'b1;
                            if (len == '0) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= S_ISSUE;
                                rom_en_q   <= 1'b1;
                                rom_addr_q <= base;
                            end
                        end
                    end
                    // ROM captures rom_addr at the end of ISSUE; en stays high
                    // through WAIT so its data output is decoded.
                    S_ISSUE: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        out_data_q  <= rom_data;
                        out_valid_q <= 1'b1;
                        rom_en_q    <= 1'b0;
                        state_q     <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            remaining_q <= remaining_q - 1'b1;
                            cur_addr_q  <= next_addr_d;
                            if (remaining_q == (ADDR_W+1)'(1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q    <= S_ISSUE;
                                rom_en_q   <= 1'b1;
                                rom_addr_q <= next_addr_d;
                            end
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rom_seq_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_seq_reader
// Bench for rom_seq_reader with a behavioural registered-address ROM. On every
// accepted start a reference process queues the addresses and words the burst
// must produce; an independent monitor compares the DUT stream against them.
// -----------------------------------------------------------------------------
module tb_rom_seq_reader;

    localparam int AW = 5;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    always #5 clk = ~clk;

    rom_seq_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base     (base),
        .len      (len),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // ROM contents; upper half mirrors the lower 16 entries.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        case (a[3:0])
            4'd0:  return 4'h2;  4'd1:  return 4'h2;
            4'd2:  return 4'hE;  4'd3:  return 4'h2;
            4'd4:  return 4'h4;  4'd5:  return 4'hA;
            4'd6:  return 4'hC;  4'd7:  return 4'h0;
            4'd8:  return 4'hA;  4'd9:  return 4'h2;
            4'd10: return 4'hE;  4'd11: return 4'h2;
            4'd12: return 4'h4;  4'd13: return 4'hA;
            4'd14: return 4'hC;  default: return 4'h0;
        endcase
    endfunction

    // Registered-address ROM: address captured while en, data decoded while en.
    logic [AW-1:0] rom_areg = '0;
    always @(posedge clk) if (rom_en) rom_areg <= rom_addr;
    assign rom_data = rom_en ? rom_word(rom_areg) : '0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    logic [DW-1:0] exp_data[$];
    logic [AW-1:0] exp_addr[$];
    int            exp_done = 0;
    int            last_evt = 0;

    // Reference: an accepted start yields len words from base, base+1, ...
    always @(negedge clk) begin
        if (!rst && start && !busy) begin
            for (int i = 0; i < int'(len); i++) begin
                logic [AW-1:0] a;
                a = base + AW'(i);
                exp_addr.push_back(a);
                exp_data.push_back(rom_word(a));
            end
            exp_done++;
            last_evt = cyc;
        end
    end

    // Monitor
    logic          prev_valid = 1'b0;
    logic          prev_en    = 1'b0;
    logic          prev_taken = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            exp_data.delete();
            exp_addr.delete();
            exp_done   = 0;
            prev_valid = 1'b0;
            prev_en    = 1'b0;
        end else begin
            if (rom_en && !prev_en) begin
                chk("rom_en_expected", int'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) chk("rom_addr", int'(rom_addr), int'(exp_addr.pop_front()));
            end
            if (out_valid) chk("rom_en_while_presenting", int'(rom_en), 0);
            if (out_valid && !prev_valid) chk("valid_latency", cyc - last_evt, 3);
            if (prev_valid && !prev_taken) begin
                chk("valid_hold", int'(out_valid), 1);
                chk("data_hold", int'(out_data), int'(prev_data));
            end
            if (out_valid && out_ready && !abort) begin
                chk("word_expected", int'(exp_data.size() > 0), 1);
                if (exp_data.size() > 0) chk("out_data", int'(out_data), int'(exp_data.pop_front()));
                last_evt = cyc;
            end
            if (done) begin
                chk("done_expected", int'(exp_done > 0), 1);
                chk("done_timing", cyc - last_evt, 1);
                chk("done_all_words", exp_data.size(), 0);
                if (exp_done > 0) exp_done--;
            end
            if (busy && abort) begin
                exp_data.delete();
                exp_addr.delete();
                exp_done = 0;
            end
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_taken = out_ready || abort;
            prev_en    = rom_en;
        end
    end

    task automatic start_burst(input logic [AW-1:0] b, input logic [AW:0] l, input logic ab);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l; abort = ab;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
        chk("remaining_words", exp_data.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base = '0; len = '0; abort = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rom_en", int'(rom_en), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst: E, 2, 4, A
        out_ready = 1'b1;
        start_burst(5'd2, 6'd4, 1'b0);
        wait_idle(50);

        // Backpressure: A held for 6 stalled cycles, then C
        out_ready = 1'b0;
        start_burst(5'd5, 6'd2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        repeat (6) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_data", int'(out_data), 4'hA);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle(50);

        // Wrap 31 -> 0
        start_burst(5'd31, 6'd2, 1'b0);
        wait_idle(50);

        // Zero length
        start_burst(5'd7, 6'd0, 1'b0);
        chk("len0_done", int'(done), 1);
        wait_idle(10);

        // Abort in PRESENT of the third word
        start_burst(5'd0, 6'd8, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_pre_valid", int'(out_valid), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        start_burst(5'd8, 6'd1, 1'b0);
        wait_idle(50);

        // Asynchronous reset during WAIT
        start_burst(5'd3, 6'd4, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_rom_en", int'(rom_en), 0);
        chk("arst_rom_addr", int'(rom_addr), 0);
        chk("arst_out_data", int'(out_data), 0);
        chk("arst_out_valid", int'(out_valid), 0);
        start = 1'b1; base = 5'd9; len = 6'd3;
        @(posedge clk); #1;
        chk("start_in_rst", int'(busy), 0);
        start = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", int'(busy), 0);
        start_burst(5'd6, 6'd2, 1'b0);
        wait_idle(50);

        // start while busy is ignored: 2, 2, E only
        start_burst(5'd0, 6'd3, 1'b0);
        start = 1'b1; base = 5'd9; len = 6'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(50);

        // Abort together with start in IDLE must not block the start
        start_burst(5'd12, 6'd2, 1'b1);
        wait_idle(50);

        // Randomized bursts with random backpressure and occasional abort
        for (int t = 0; t < 40; t++) begin
            int sel;
            logic [AW:0] l;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      l = '0;
            else if (sel == 1) l = 6'd32;
            else               l = (AW+1)'($urandom_range(1, 6));
            out_ready = ($urandom_range(0, 9) < 7);
            start_burst(AW'($urandom), l, ($urandom_range(0, 9) == 0));
            for (int n = 0; n < 600 && busy; n++) begin
                out_ready = ($urandom_range(0, 9) < 7);
                abort     = ($urandom_range(0, 49) == 0);
                @(posedge clk); #1;
            end
            abort = 1'b0;
            chk("rand_idle", int'(busy), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
